// File: rtl/data_memory_bytewise_if.sv
// Load/store bus between the memory stage and data_memory_bytewise.
// The master drives requests and the slave (the memory) returns results.
interface data_memory_bytewise_if;
    logic        memory_read;
    logic        memory_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_valid;
    logic        busy;
    logic        misaligned;

    modport master (
        output memory_read, memory_write, funct3, address, write_data,
        input  read_data, read_valid, busy, misaligned
    );

    modport slave (
        input  memory_read, memory_write, funct3, address, write_data,
        output read_data, read_valid, busy, misaligned
    );
endinterface

// File: rtl/data_memory_bytewise.sv
// Byte-addressed, word-organised data memory with RISC-V sub-word loads
// and stores, a registered one-cycle read with valid strobe, and a clear
// sequencer that zeroes every word after reset.
// Optional macro MISALIGN_TRAP_EN: flag misaligned halfword/word accesses,
// suppress misaligned stores and return zero for misaligned loads.
module data_memory_bytewise #(
    parameter int MEMORY_SIZE    = 4096,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk,
    input  logic reset,
    data_memory_bytewise_if.slave bus
);
    localparam int DEPTH = MEMORY_SIZE / 4;
    localparam int IW    = $clog2(DEPTH);

    typedef enum logic {CLEAR, IDLE} state_t;

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state;
    logic [IW-1:0] r_clearPtr;
    logic          r_busy;
    logic [31:0]   r_readData;
    logic          r_readValid;
    logic          r_misaligned;

    logic [IW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_accept;
    logic          w_misLoad;
    logic          w_misStore;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_loadData;
    logic [3:0]    w_byteEn;
    logic [31:0]   w_storeData;
    logic          w_unusedAddr;

    // High address bits fall away so accesses wrap modulo MEMORY_SIZE.
    assign w_idx        = bus.address[IW+1:2];
    assign w_lane       = bus.address[1:0];
    assign w_unusedAddr = &{1'b0, bus.address[31:IW+2]};
    assign w_accept     = (r_state == IDLE);
    assign w_word       = r_mem[w_idx];
    assign w_byte       = w_word[{w_lane, 3'b000} +: 8];
    assign w_half       = w_lane[1] ? w_word[31:16] : w_word[15:0];

`ifdef MISALIGN_TRAP_EN
    assign w_misLoad  = (((bus.funct3 == 3'b001) || (bus.funct3 == 3'b101)) && w_lane[0])
                     || ((bus.funct3 == 3'b010) && (w_lane != 2'b00));
    assign w_misStore = ((bus.funct3 == 3'b001) && w_lane[0])
                     || ((bus.funct3 == 3'b010) && (w_lane != 2'b00));
`else
    assign w_misLoad  = 1'b0;
    assign w_misStore = 1'b0;
`endif

    // Extend the selected byte/halfword for the load result.
    always_comb begin
        w_loadData = '0;
        case (bus.funct3)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_loadData = {24'b0, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b101:  w_loadData = {16'b0, w_half};
            3'b010:  w_loadData = w_word;
            default: w_loadData = '0;
        endcase
        if (w_misLoad) begin
            w_loadData = '0;
        end
    end

    // Build byte-lane enables and lane-replicated store data.
    always_comb begin
        w_byteEn    = 4'b0000;
        w_storeData = bus.write_data;
        case (bus.funct3)
            3'b000: begin
                w_byteEn    = 4'b0001 << w_lane;
                w_storeData = {4{bus.write_data[7:0]}};
            end
            3'b001: begin
                w_byteEn    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{bus.write_data[15:0]}};
            end
            3'b010:  w_byteEn = 4'b1111;
            default: w_byteEn = 4'b0000;
        endcase
        if (w_misStore || !w_accept || !bus.memory_write) begin
            w_byteEn = 4'b0000;
        end
    end

    // Memory array: clear sequencer owns the write port while clearing,
    // otherwise stores update only their enabled byte lanes.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clearPtr] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_storeData[8*b +: 8];
                end
            end
        end
    end

    // Control FSM: walk the clear pointer, then serve loads with a
    // registered result, valid strobe and misalignment pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            r_busy       <= (CLEAR_ON_RESET != 0);
            r_clearPtr   <= '0;
            r_readData   <= '0;
            r_readValid  <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_readValid  <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_clearPtr <= r_clearPtr + 1'b1;
                    if (r_clearPtr == IW'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (bus.memory_read) begin
                        r_readData  <= w_loadData;
                        r_readValid <= 1'b1;
                    end
                    r_misaligned <= (bus.memory_read & w_misLoad)
                                  | (bus.memory_write & w_misStore);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.read_data  = r_readData;
    assign bus.read_valid = r_readValid;
    assign bus.busy       = r_busy;
    assign bus.misaligned = r_misaligned;
endmodule

// File: tb/tb_data_memory_bytewise.sv
// Self-checking bench for data_memory_bytewise (64-byte, clear on reset).
// Loads push their expected result into a scoreboard when driven; a
// monitor pops and compares whenever read_valid is seen.
module tb_data_memory_bytewise;
    localparam int MEM_SIZE = 64;
    localparam int DEPTH    = MEM_SIZE / 4;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
        logic [31:0] due;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   nChecks = 0;
    int   nFail   = 0;
    int   cycleNo = 0;
    vec_t vecs[$];
    sb_t  sb[$];

    data_memory_bytewise_if dmIf ();

    data_memory_bytewise #(.MEMORY_SIZE(MEM_SIZE), .CLEAR_ON_RESET(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dmIf)
    );

    // Free-running clock and cycle counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Give up if anything stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Drive one request cycle; loads register their expected result.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp, input logic mis);
        sb_t e;
        dmIf.memory_read  = rd;
        dmIf.memory_write = wr;
        dmIf.funct3       = f3;
        dmIf.address      = addr;
        dmIf.write_data   = wdata;
        if (rd) begin
            e.data = exp;
            e.mis  = mis;
            e.due  = 32'(cycleNo + 1);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic addVec(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Count edges after reset release until busy drops.
    task automatic countBusy(output int cnt);
        cnt = 0;
        while (dmIf.busy && cnt < 100) begin
            @(posedge clk);
            cnt++;
            #1;
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (dmIf.read_valid === 1'b1) begin
            if (sb.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpectedValid actual=1 required=0 at cycle %0d", cycleNo);
            end else begin
                sb_t e;
                e = sb.pop_front();
                checkOutput("readData", dmIf.read_data, e.data);
                checkOutput("readCycle", 32'(cycleNo), e.due);
                checkOutput("readMis", {31'b0, dmIf.misaligned}, {31'b0, e.mis});
            end
        end
    end

    initial begin
        int cnt;
        logic [31:0] lastExp;

        // Directed vector table, applied back to back.
        addVec(0, 1, 3'b010, 32'h10, 32'h11223344, 0);
        addVec(0, 1, 3'b000, 32'h11, 32'h000000AA, 0);
        addVec(0, 1, 3'b001, 32'h12, 32'h0000BEEF, 0);
        addVec(1, 0, 3'b010, 32'h10, 0, 32'hBEEFAA44);
        addVec(0, 1, 3'b000, 32'h13, 32'h00000055, 0);
        addVec(1, 0, 3'b010, 32'h10, 0, 32'h55EFAA44);
        addVec(0, 1, 3'b010, 32'h20, 32'h80F07F81, 0);
        addVec(1, 0, 3'b000, 32'h20, 0, 32'hFFFFFF81);
        addVec(1, 0, 3'b100, 32'h23, 0, 32'h00000080);
        addVec(1, 0, 3'b001, 32'h22, 0, 32'hFFFF80F0);
        addVec(1, 0, 3'b101, 32'h20, 0, 32'h00007F81);
        addVec(1, 0, 3'b000, 32'h21, 0, 32'h0000007F);
        addVec(1, 0, 3'b011, 32'h20, 0, 32'h00000000);
        addVec(0, 1, 3'b011, 32'h20, 32'hFFFFFFFF, 0);
        addVec(1, 0, 3'b010, 32'h20, 0, 32'h80F07F81);
`ifndef MISALIGN_TRAP_EN
        addVec(1, 0, 3'b001, 32'h23, 0, 32'hFFFF80F0);
        addVec(1, 0, 3'b010, 32'h22, 0, 32'h80F07F81);
`endif
        addVec(0, 1, 3'b010, 32'h30, 32'h00000005, 0);
        addVec(1, 1, 3'b010, 32'h30, 32'h00000009, 32'h00000005);
        addVec(1, 0, 3'b010, 32'h30, 0, 32'h00000009);
        addVec(0, 1, 3'b010, 32'(MEM_SIZE + 4), 32'h0000CAFE, 0);
        addVec(1, 0, 3'b010, 32'h04, 0, 32'h0000CAFE);

        dmIf.memory_read = 0; dmIf.memory_write = 0; dmIf.funct3 = 0;
        dmIf.address = 0; dmIf.write_data = 0;

        // Reset state and clear length, with a request attempted mid-clear.
        #2 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rstReadData", dmIf.read_data, 32'h0);
        checkOutput("rstReadValid", {31'b0, dmIf.read_valid}, 32'h0);
        checkOutput("rstBusy", {31'b0, dmIf.busy}, 32'h1);
        checkOutput("rstMisaligned", {31'b0, dmIf.misaligned}, 32'h0);
        reset = 1'b0;
        cnt = 0;
        while (dmIf.busy && cnt < 100) begin
            if (cnt == 4) begin
                dmIf.memory_read = 1; dmIf.memory_write = 1; dmIf.funct3 = 3'b010;
                dmIf.address = 32'h8; dmIf.write_data = 32'hDEADBEEF;
            end else begin
                dmIf.memory_read = 0; dmIf.memory_write = 0;
            end
            @(posedge clk);
            cnt++;
            #1;
        end
        dmIf.memory_read = 0; dmIf.memory_write = 0;
        checkOutput("busyCycles", 32'(cnt), 32'(DEPTH));

        // Every word reads back zero, one result per cycle.
        for (int w = 0; w < DEPTH; w++) applyStimulus(1, 0, 3'b010, 32'(w * 4), 0, 32'h0, 1'b0);
        idleCycles(2);

        // Table-driven vectors.
        lastExp = 0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                          vecs[i].wdata, vecs[i].exp, 1'b0);
            if (vecs[i].rd) lastExp = vecs[i].exp;
        end
        idleCycles(3);
        checkOutput("readHold", dmIf.read_data, lastExp);

`ifdef MISALIGN_TRAP_EN
        // Misaligned store is dropped and flagged; misaligned load returns zero.
        applyStimulus(0, 1, 3'b010, 32'h40, 32'h12345678, 0, 1'b0);
        applyStimulus(0, 1, 3'b010, 32'h41, 32'h00001234, 0, 1'b0);
        @(negedge clk);
        checkOutput("misStore", {31'b0, dmIf.misaligned}, 32'h1);
        applyStimulus(1, 0, 3'b010, 32'h40, 0, 32'h12345678, 1'b0);
        applyStimulus(1, 0, 3'b001, 32'h43, 0, 32'h00000000, 1'b1);
        idleCycles(2);
`endif

        // Reset reasserted at clear cycle 7 restarts the full clear.
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst2ReadData", dmIf.read_data, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midClearBusy", {31'b0, dmIf.busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        countBusy(cnt);
        checkOutput("busyCyclesRestart", 32'(cnt), 32'(DEPTH));
        applyStimulus(1, 0, 3'b010, 32'h04, 0, 32'h0, 1'b0);
        applyStimulus(1, 0, 3'b010, 32'h30, 0, 32'h0, 1'b0);
        idleCycles(3);

        checkOutput("scoreboardDrained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/data_memory_bytewise.md
Name: data_memory_bytewise

Overview:
- Byte-addressed, word-organised data memory for the core's load/store stage.
- Successor to the flat word memory: adds RISC-V sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW), a registered one-cycle read with valid strobe, and a hardware clear sequencer after reset.
- Sits between the execute/memory stage and the pipeline writeback mux.

Parameters:
- MEMORY_SIZE, 4096: capacity in bytes; power of two, at least 8.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset via the clear FSM; 0 = skip the clear, contents undefined after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- memory_read  input  1  load request, sampled on the rising edge.
- memory_write  input  1  store request, sampled on the rising edge.
- funct3  input  3  RISC-V access size/sign encoding.
- address  input  32  byte address.
- write_data  input  32  store data; low byte/halfword used for SB/SH.
- read_data  output  32  extended load result.
- read_valid  output  1  one-cycle strobe qualifying read_data.
- busy  output  1  clear in progress; requests are ignored while high.
- misaligned  output  1  misaligned-access strobe; tied 0 unless MISALIGN_TRAP_EN is defined.

Behaviour:
- Geometry: DEPTH = MEMORY_SIZE/4 words; IW = clog2(DEPTH); word index = address[IW+1:2].
- Address bits above IW+1 are ignored, so addresses wrap modulo MEMORY_SIZE.
- Reset values: read_data = 0, read_valid = 0, misaligned = 0, clear_ptr = 0.
- On reset, state = CLEAR and busy = 1 if CLEAR_ON_RESET = 1; otherwise state = IDLE and busy = 0.
- FSM states: CLEAR and IDLE.
- CLEAR, each cycle:
  - write ram[clear_ptr] = 0, then clear_ptr++.
  - when clear_ptr == DEPTH-1, that word is written and the next state is IDLE.
  - busy falls on the same edge that enters IDLE, so the clear takes exactly DEPTH cycles after reset release.
- Reset asserted mid-clear: restart from clear_ptr = 0.
- Requests during CLEAR: ignored. No write, no read_valid, no misaligned.
- Stores (IDLE, memory_write = 1):
  - funct3 000 SB: write_data[7:0] to byte lane address[1:0].
  - funct3 001 SH: write_data[15:0] to lanes {address[1],0} and {address[1],1}.
  - funct3 010 SW: full word.
  - All other funct3 values: no write.
  - Unselected bytes of the word are unchanged.
- Loads (IDLE, memory_read = 1):
  - read_data and read_valid are registered and appear on the next edge.
  - read_valid is high for exactly one cycle per accepted request.
  - funct3 000 LB sign-extends the byte; 100 LBU zero-extends it.
  - funct3 001 LH sign-extends the halfword; 101 LHU zero-extends it.
  - funct3 010 LW returns the full word.
  - Other funct3 values: read_data = 0 with read_valid = 1.
  - read_data holds its last value while read_valid = 0.
- Back-to-back reads: one result per cycle, no bubbles.
- Simultaneous read and write in the same cycle: both execute. The read returns the pre-write contents (read-before-write, including the same address).
- Misalignment without the macro:
  - halfword accesses ignore address[0].
  - word accesses ignore address[1:0].

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- With the macro defined, the misaligned condition is: LH/LHU/SH with address[0] = 1, or LW/SW with address[1:0] != 0.
- On a misaligned store: the write is suppressed; misaligned pulses for one cycle on the next edge.
- On a misaligned load: read_data = 0 and read_valid = 1, with misaligned = 1 in the same cycle.
- Without the macro: misaligned is constant 0 and accesses are truncated as described under Behaviour.

Test Plan:
- Clear sequence: MEMORY_SIZE = 64, CLEAR_ON_RESET = 1, pulse reset → busy high for exactly 16 cycles after release; a write attempted at cycle 5 is ignored; afterwards LW of every word returns 0x00000000.
- Sub-word stores: SW 0x11223344 @0x10, then SB 0xAA @0x11, then SH 0xBEEF @0x12 → LW @0x10 returns 0xBEEFAA44, with read_valid one cycle after the request.
- Load extension: word 0x80F07F81 @0x20 →
  - LB @0x20 = 0xFFFFFF81.
  - LBU @0x23 = 0x00000080.
  - LH @0x22 = 0xFFFF80F0.
  - LHU @0x20 = 0x00007F81.
- Read-before-write: SW 0x5 @0x30, then the same cycle issue LW @0x30 and SW 0x9 @0x30 → read returns 0x5; the following LW returns 0x9.
- Wrap and reset mid-clear:
  - SW 0xCAFE @(MEMORY_SIZE+4) → LW @0x4 returns 0x0000CAFE.
  - Reassert reset at clear cycle 7 → busy stays high for a full DEPTH cycles after the final release.
- MISALIGN_TRAP_EN defined: SW 0x1234 @0x41 → misaligned = 1 next cycle and memory unchanged; LH @0x43 → read_valid = 1, read_data = 0, misaligned = 1.
